// File: rtl/ysyx_24090012_axi_arbiter_pkg.sv
// ysyx_24090012_axi_arbiter_pkg: FSM encodings, AXI constants and round-robin helper for the arbiter
package ysyx_24090012_axi_arbiter_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2
  } state_t;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic PORT_S0 = 1'b0;
  localparam logic PORT_S1 = 1'b1;
  function automatic logic rr_pick(input logic req0, input logic req1, input logic last_grant);
    return (req0 & req1) ? ~last_grant : req1;
  endfunction
endpackage

// File: rtl/ysyx_24090012_axi_arbiter_if.sv
// ysyx_24090012_axi_arbiter_if: full AXI4 bundle; master drives requests, slave drives responses
interface ysyx_24090012_axi_arbiter_if;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic [3:0]  bid;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic [3:0]  rid;
  logic        rlast;
  modport master (
    output awvalid, awaddr, awid, awlen, awsize, awburst,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bresp, bid,
    output bready,
    output arvalid, araddr, arid, arlen, arsize, arburst,
    input  arready,
    input  rvalid, rdata, rresp, rid, rlast,
    output rready
  );
  modport slave (
    input  awvalid, awaddr, awid, awlen, awsize, awburst,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bresp, bid,
    input  bready,
    input  arvalid, araddr, arid, arlen, arsize, arburst,
    output arready,
    output rvalid, rdata, rresp, rid, rlast,
    input  rready
  );
endinterface

// File: rtl/ysyx_24090012_axi_arbiter.sv
// ysyx_24090012_axi_arbiter: round-robin 2:1 AXI4 arbiter (IFU/LSU) with one outstanding transaction
module ysyx_24090012_axi_arbiter
  import ysyx_24090012_axi_arbiter_pkg::*;
(
  input  logic                           clock,
  input  logic                           reset,
  ysyx_24090012_axi_arbiter_if.slave     s0,
  ysyx_24090012_axi_arbiter_if.slave     s1,
  ysyx_24090012_axi_arbiter_if.master    io_master
);
  state_t state, state_n;
  logic owner, last_grant, aw_done, w_done, ar_done;
  logic req0, req1, take, pick, pick_wr, wr, rd;
  logic own_awvalid, own_wvalid, own_wlast, own_bready, own_arvalid, own_rready;
  logic aw_en, w_en, ar_en, aw_fire, w_fire_last, ar_fire, b_fire, r_fire_last;
  assign req0 = s0.awvalid | s0.arvalid;
  assign req1 = s1.awvalid | s1.arvalid;
  assign take = (state == IDLE) & (req0 | req1);
  assign pick = rr_pick(req0, req1, last_grant);
  assign pick_wr = pick ? s1.awvalid : s0.awvalid;
  assign wr = ~reset & (state == WR);
  assign rd = ~reset & (state == RD);
  assign own_awvalid = owner ? s1.awvalid : s0.awvalid;
  assign own_wvalid = owner ? s1.wvalid : s0.wvalid;
  assign own_wlast = owner ? s1.wlast : s0.wlast;
  assign own_bready = owner ? s1.bready : s0.bready;
  assign own_arvalid = owner ? s1.arvalid : s0.arvalid;
  assign own_rready = owner ? s1.rready : s0.rready;
  // Each address/data phase is forwarded once per grant, so a master that keeps valid high cannot issue a second transaction
  assign aw_en = wr & ~aw_done;
  assign w_en = wr & ~w_done;
  assign ar_en = rd & ~ar_done;
  assign aw_fire = aw_en & own_awvalid & io_master.awready;
  assign w_fire_last = w_en & own_wvalid & own_wlast & io_master.wready;
  assign ar_fire = ar_en & own_arvalid & io_master.arready;
  assign b_fire = wr & io_master.bvalid & own_bready;
  assign r_fire_last = rd & io_master.rvalid & own_rready & io_master.rlast;
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      owner <= PORT_S0;
      last_grant <= PORT_S1;
      aw_done <= 1'b0;
      w_done <= 1'b0;
      ar_done <= 1'b0;
    end else begin
      state <= state_n;
      if (take) begin
        owner <= pick;
        last_grant <= pick;
        aw_done <= 1'b0;
        w_done <= 1'b0;
        ar_done <= 1'b0;
      end else begin
        aw_done <= aw_done | aw_fire;
        w_done <= w_done | w_fire_last;
        ar_done <= ar_done | ar_fire;
      end
    end
  end
  always_comb begin
    state_n = state;
    if (take) state_n = pick_wr ? WR : RD;
    if (state == WR && b_fire) state_n = IDLE;
    if (state == RD && r_fire_last) state_n = IDLE;
  end
  always_comb begin
    io_master.awvalid = aw_en & own_awvalid;
    io_master.awaddr = owner ? s1.awaddr : s0.awaddr;
    io_master.awid = owner ? s1.awid : s0.awid;
    io_master.awlen = owner ? s1.awlen : s0.awlen;
    io_master.awsize = owner ? s1.awsize : s0.awsize;
    io_master.awburst = owner ? s1.awburst : s0.awburst;
    io_master.wvalid = w_en & own_wvalid;
    io_master.wdata = owner ? s1.wdata : s0.wdata;
    io_master.wstrb = owner ? s1.wstrb : s0.wstrb;
    io_master.wlast = own_wlast;
    io_master.bready = wr & own_bready;
    io_master.arvalid = ar_en & own_arvalid;
    io_master.araddr = owner ? s1.araddr : s0.araddr;
    io_master.arid = owner ? s1.arid : s0.arid;
    io_master.arlen = owner ? s1.arlen : s0.arlen;
    io_master.arsize = owner ? s1.arsize : s0.arsize;
    io_master.arburst = owner ? s1.arburst : s0.arburst;
    io_master.rready = rd & own_rready;
  end
  always_comb begin
    s0.awready = aw_en & ~owner & io_master.awready;
    s0.wready = w_en & ~owner & io_master.wready;
    s0.bvalid = wr & ~owner & io_master.bvalid;
    s0.bresp = io_master.bresp;
    s0.bid = io_master.bid;
    s0.arready = ar_en & ~owner & io_master.arready;
    s0.rvalid = rd & ~owner & io_master.rvalid;
    s0.rdata = io_master.rdata;
    s0.rresp = io_master.rresp;
    s0.rid = io_master.rid;
    s0.rlast = io_master.rlast;
    s1.awready = aw_en & owner & io_master.awready;
    s1.wready = w_en & owner & io_master.wready;
    s1.bvalid = wr & owner & io_master.bvalid;
    s1.bresp = io_master.bresp;
    s1.bid = io_master.bid;
    s1.arready = ar_en & owner & io_master.arready;
    s1.rvalid = rd & owner & io_master.rvalid;
    s1.rdata = io_master.rdata;
    s1.rresp = io_master.rresp;
    s1.rid = io_master.rid;
    s1.rlast = io_master.rlast;
  end
endmodule

// File: tb/tb_ysyx_24090012_axi_arbiter.sv
// tb_ysyx_24090012_axi_arbiter: directed checks of grant order, routing, burst ownership and reset abort
module tb_ysyx_24090012_axi_arbiter;
  import ysyx_24090012_axi_arbiter_pkg::*;
  logic clock, reset;
  int errors, checks;
  ysyx_24090012_axi_arbiter_if s0 ();
  ysyx_24090012_axi_arbiter_if s1 ();
  ysyx_24090012_axi_arbiter_if m ();
  ysyx_24090012_axi_arbiter dut (.clock(clock), .reset(reset), .s0(s0), .s1(s1), .io_master(m));
  initial clock = 1'b0;
  always #5 clock = ~clock;
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic nxt;
    @(posedge clock);
    #1;
  endtask
  task automatic settle;
    #1;
  endtask
  task automatic clear;
    s0.awvalid = 0; s0.awaddr = 0; s0.awid = 0; s0.awlen = 0; s0.awsize = 3'd2; s0.awburst = BURST_INCR;
    s0.wvalid = 0; s0.wdata = 0; s0.wstrb = 0; s0.wlast = 0; s0.bready = 0;
    s0.arvalid = 0; s0.araddr = 0; s0.arid = 0; s0.arlen = 0; s0.arsize = 3'd2; s0.arburst = BURST_INCR; s0.rready = 0;
    s1.awvalid = 0; s1.awaddr = 0; s1.awid = 0; s1.awlen = 0; s1.awsize = 3'd2; s1.awburst = BURST_INCR;
    s1.wvalid = 0; s1.wdata = 0; s1.wstrb = 0; s1.wlast = 0; s1.bready = 0;
    s1.arvalid = 0; s1.araddr = 0; s1.arid = 0; s1.arlen = 0; s1.arsize = 3'd2; s1.arburst = BURST_INCR; s1.rready = 0;
    m.awready = 0; m.wready = 0; m.bvalid = 0; m.bresp = RESP_OKAY; m.bid = 0;
    m.arready = 0; m.rvalid = 0; m.rdata = 0; m.rresp = RESP_OKAY; m.rid = 0; m.rlast = 0;
  endtask
  task automatic do_reset;
    reset = 1;
    clear;
    nxt;
    nxt;
    reset = 0;
  endtask
  task automatic tie_round(input logic w);
    nxt;
    m.arready = 1;
    settle;
    check("tie_s0_arready", s0.arready, !w);
    check("tie_s1_arready", s1.arready, w);
    check("tie_araddr", m.araddr, w ? 32'h200 : 32'h100);
    nxt;
    m.arready = 0; m.rvalid = 1; m.rlast = 1; m.rid = {3'b0, w};
    settle;
    check("tie_s0_rvalid", s0.rvalid, !w);
    check("tie_s1_rvalid", s1.rvalid, w);
    nxt;
    m.rvalid = 0; m.rlast = 0;
    settle;
    check("tie_idle", dut.state, IDLE);
  endtask
  initial begin
    errors = 0;
    checks = 0;
    reset = 1;
    clear;
    s0.arvalid = 1;
    m.arready = 1;
    nxt;
    nxt;
    settle;
    check("rst_state", dut.state, IDLE);
    check("rst_m_arvalid", m.arvalid, 0);
    check("rst_s0_arready", s0.arready, 0);
    check("rst_m_rready", m.rready, 0);
    clear;
    nxt;
    reset = 0;
    // single s0 read
    s0.arvalid = 1; s0.araddr = 32'h8000_0000; s0.arid = 4'h3;
    settle;
    check("t1_idle_arvalid", m.arvalid, 0);
    nxt;
    m.arready = 1;
    settle;
    check("t1_arvalid", m.arvalid, 1);
    check("t1_araddr", m.araddr, 32'h8000_0000);
    check("t1_s0_arready", s0.arready, 1);
    check("t1_s1_arready", s1.arready, 0);
    nxt;
    s0.arvalid = 0; m.arready = 0; m.rvalid = 1; m.rdata = 32'h1234_5678; m.rid = 4'h3; m.rlast = 1; s0.rready = 1; s1.rready = 1;
    settle;
    check("t1_s0_rvalid", s0.rvalid, 1);
    check("t1_s0_rdata", s0.rdata, 32'h1234_5678);
    check("t1_s0_rid", s0.rid, 4'h3);
    check("t1_s1_rvalid", s1.rvalid, 0);
    check("t1_m_rready", m.rready, 1);
    nxt;
    m.rvalid = 0; m.rlast = 0;
    settle;
    check("t1_idle", dut.state, IDLE);
    // repeated ties alternate starting with s0
    do_reset;
    s0.arvalid = 1; s0.araddr = 32'h100; s1.arvalid = 1; s1.araddr = 32'h200; s0.rready = 1; s1.rready = 1;
    tie_round(0);
    tie_round(1);
    tie_round(0);
    tie_round(1);
    // write wins over read on the same port
    do_reset;
    s0.awvalid = 1; s0.arvalid = 1;
    nxt;
    settle;
    check("wf_state", dut.state, WR);
    check("wf_m_arvalid", m.arvalid, 0);
    check("wf_m_awvalid", m.awvalid, 1);
    // s1 write with slow awready
    do_reset;
    s1.awvalid = 1; s1.awaddr = 32'h8000_0100; s1.awid = 4'h5;
    s1.wvalid = 1; s1.wdata = 32'hDEAD_BEEF; s1.wstrb = 4'hF; s1.wlast = 1; s1.bready = 1;
    nxt;
    for (int i = 0; i < 3; i++) begin
      settle;
      check("t3_awvalid", m.awvalid, 1);
      check("t3_awaddr", m.awaddr, 32'h8000_0100);
      check("t3_s1_awready", s1.awready, 0);
      nxt;
    end
    m.awready = 1;
    settle;
    check("t3_s1_awready_hs", s1.awready, 1);
    check("t3_s0_awready", s0.awready, 0);
    nxt;
    s1.awvalid = 0; m.awready = 0; m.wready = 1;
    settle;
    check("t3_wvalid", m.wvalid, 1);
    check("t3_wdata", m.wdata, 32'hDEAD_BEEF);
    check("t3_wstrb", m.wstrb, 4'hF);
    check("t3_s1_wready", s1.wready, 1);
    check("t3_s0_wready", s0.wready, 0);
    nxt;
    s1.wvalid = 0; m.wready = 0; m.bvalid = 1; m.bid = 4'h5;
    settle;
    check("t3_s1_bvalid", s1.bvalid, 1);
    check("t3_s1_bid", s1.bid, 4'h5);
    check("t3_s0_bvalid", s0.bvalid, 0);
    check("t3_m_bready", m.bready, 1);
    nxt;
    m.bvalid = 0;
    settle;
    check("t3_idle", dut.state, IDLE);
    // s1 waits out an s0 four-beat burst
    do_reset;
    s0.arvalid = 1; s0.arlen = 8'd3; s0.arid = 4'h1; s0.rready = 1; s1.rready = 1;
    nxt;
    m.arready = 1;
    settle;
    check("t4_s0_arready", s0.arready, 1);
    nxt;
    s0.arvalid = 0; m.arready = 1; s1.arvalid = 1; s1.araddr = 32'h300;
    for (int i = 0; i < 4; i++) begin
      m.rvalid = 1; m.rlast = (i == 3);
      settle;
      check("t4_s0_rvalid", s0.rvalid, 1);
      check("t4_s1_arready", s1.arready, 0);
      check("t4_m_arvalid", m.arvalid, 0);
      nxt;
    end
    m.rvalid = 0; m.rlast = 0;
    settle;
    check("t4_idle", dut.state, IDLE);
    nxt;
    settle;
    check("t4_s1_arready", s1.arready, 1);
    check("t4_s1_araddr", m.araddr, 32'h300);
    check("t4_s0_arready", s0.arready, 0);
    // reset abandons a pending read
    do_reset;
    s0.arvalid = 1;
    nxt;
    m.arready = 1;
    nxt;
    s0.arvalid = 0; m.arready = 0; m.rvalid = 1; m.rlast = 1; s0.rready = 0;
    settle;
    check("t5_pend_rvalid", s0.rvalid, 1);
    nxt;
    reset = 1;
    settle;
    check("t5_rst_rvalid", s0.rvalid, 0);
    nxt;
    reset = 0;
    settle;
    check("t5_state", dut.state, IDLE);
    check("t5_s0_rvalid", s0.rvalid, 0);
    check("t5_s1_rvalid", s1.rvalid, 0);
    check("t5_m_rready", m.rready, 0);
    check("t5_m_arvalid", m.arvalid, 0);
    check("t5_s0_arready", s0.arready, 0);
    // error response forwarded on s1 write
    do_reset;
    s1.awvalid = 1; s1.awid = 4'h7; s1.wvalid = 1; s1.wlast = 1; s1.bready = 1;
    nxt;
    m.awready = 1; m.wready = 1;
    nxt;
    s1.awvalid = 0; s1.wvalid = 0; m.awready = 0; m.wready = 0; m.bvalid = 1; m.bresp = 2'b10; m.bid = 4'h7;
    settle;
    check("t6_s1_bvalid", s1.bvalid, 1);
    check("t6_s1_bresp", s1.bresp, 2'b10);
    check("t6_s0_bvalid", s0.bvalid, 0);
    nxt;
    m.bvalid = 0;
    settle;
    check("t6_idle", dut.state, IDLE);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ysyx_24090012_axi_arbiter.md
YSYX_24090012_AXI_ARBITER -- requirements
Module: ysyx_24090012_axi_arbiter

Interface
REQ-001 SHALL have `clock`, input, 1 bit: system clock; all state updates on its rising edge.
REQ-002 SHALL have `reset`, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have `s0_aw{valid,addr[32],id[4],len[8],size[3],burst[2]}` inputs and `s0_awready` output: IFU write-address channel.
REQ-004 SHALL have `s0_w{valid,data[32],strb[4],last}` inputs and `s0_wready` output: IFU write-data channel.
REQ-005 SHALL have `s0_bready` input and `s0_b{valid,resp[2],id[4]}` outputs: IFU write-response channel.
REQ-006 SHALL have `s0_ar{valid,addr[32],id[4],len[8],size[3],burst[2]}` inputs and `s0_arready` output: IFU read-address channel.
REQ-007 SHALL have `s0_rready` input and `s0_r{valid,data[32],resp[2],id[4],last}` outputs: IFU read-data channel.
REQ-008 SHALL have `s1_*`, with the same set as REQ-003..007: LSU slave port, driven by LSU `io_master_*`.
REQ-009 SHALL have `io_master_*`, with the mirrored full AXI4 master set (same widths): single downstream port to the crossbar/SoC.

Function
REQ-010 SHALL hold at most one outstanding transaction system-wide; FSM states are IDLE, WR (write owned), RD (read owned).
REQ-011 SHALL define per-port request as awvalid|arvalid; if a port asserts both, the write is served first.
REQ-012 SHALL, in IDLE with any request, register grant (owner, is_write) at that edge and enter WR/RD; forwarding starts the following cycle (1-cycle arbitration latency, no combinational valid path in IDLE).
REQ-013 SHALL arbitrate round-robin: on simultaneous s0/s1 requests, grant the port not granted last; a single requester always wins.
REQ-014 SHALL, in WR/RD, route the owner's AW/W/AR payload and valid to io_master combinationally, return io_master ready signals to the owner only, and return B/R channel fields (resp and id passed unchanged) to the owner only.
REQ-015 SHALL hold the non-owner's readys and response valids at 0 in every state; in IDLE all io_master valids and readys are 0.
REQ-016 SHALL leave WR to IDLE on io_master_bvalid & bready, and leave RD to IDLE on io_master_rvalid & rready & rlast.
REQ-017 SHALL update last_grant only when a grant is taken, and SHALL NOT re-arbitrate mid-burst (len>0 reads stay owned until rlast).
REQ-018 SHALL NOT change ownership or drop valid while an owned valid is pending, even if the other port requests.
REQ-019 SHALL treat an error resp (bresp/rresp≠0) as a normal completion and forward it unchanged.

Reset
REQ-020 SHALL, on reset, set state=IDLE and last_grant=s1 (so s0 wins the first tie), and drive all valid and ready outputs to 0.
REQ-021 SHALL, on reset mid-transaction, abandon the transaction immediately with no completion; the next cycle is IDLE.

Structure
REQ-022 SHALL place state encodings (IDLE=2'd0, WR=2'd1, RD=2'd2) and AXI constants (RESP_OKAY=2'b00, BURST_INCR=2'b01) in the shared package.
REQ-023 SHALL be a single module with no sub-module; the per-channel routing mux is inline.

Verification
REQ-024 SHALL cover: s0 ar addr=0x8000_0000 alone -> io_master_arvalid rises 1 cycle later; rdata 0x1234_5678 rlast=1 returns to s0 only; FSM returns to IDLE.
REQ-025 SHALL cover: s0 ar and s1 ar both valid from reset -> s0 served first, s1 next; with a repeated tie, s1 then s0 alternate.
REQ-026 SHALL cover: s1 write addr=0x8000_0100 data=0xDEAD_BEEF strb=0xF with awready delayed 3 cycles -> awvalid/payload stable throughout, then W, then bvalid bid=s1_awid reaches s1 only.
REQ-027 SHALL cover: s1 raises arvalid during an s0 len=3 read burst -> s1_arready stays 0 until the 4th beat with rlast, then s1 is granted.
REQ-028 SHALL cover: reset asserted while in RD with rvalid pending -> the next cycle all valids and readys are 0, state=IDLE, and no s*_rvalid is seen.
REQ-029 SHALL cover: bresp=2'b10 on an s1 write -> forwarded to s1 as 2'b10, and the arbiter returns to IDLE.
